ysyx_25040129_lsu: RTL
======================

Name: ysyx_25040129_lsu

Overview:
Multi-cycle load/store unit replacing the single-cycle DPI-backed memory stage. It accepts one memory op from the execute stage over a valid/ready handshake and issues one word-aligned bus request with byte strobes. It waits for the response under a timeout, aligns and extends load data, and returns a result with an error cause. This is the boundary between core and memory bus for the multi-cycle core.

Parameters:
ADDR_W, 32, address width of in_addr and mem_req_addr
TIMEOUT_CYCLES, 255, maximum cycles in WAIT before a timeout error; must be >= 1
MISALIGN_TRAP, 1, 1 = misaligned access returns error without bus access; 0 = access issued to the aligned-down word (legacy behaviour)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  op request from EXU
in_ready  out  1  LSU can accept an op
in_is_store  in  1  1 = store, 0 = load
in_funct3  in  3  RV32 load/store funct3
in_addr  in  ADDR_W  effective byte address
in_wdata  in  32  store data (rs2)
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
mem_req_wen  out  1  1 = write
mem_req_wdata  out  32  lane-steered write data
mem_req_wstrb  out  4  byte enables (0 for loads)
mem_rsp_valid  in  1  bus response valid
mem_rsp_ready  out  1  LSU accepts response
mem_rsp_rdata  in  32  read word
mem_rsp_err  in  1  bus error
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
out_rdata  out  32  extended load data (0 for stores and errors)
out_err  out  1  op failed
out_cause  out  2  0 none, 1 misaligned/illegal, 2 bus error, 3 timeout

Behaviour:
- Reset (rst=0, async): state=IDLE. Outputs: mem_req_valid=0, out_valid=0, out_err=0, out_cause=0, out_rdata=0, mem_req_* registers 0, timeout counter 0. in_ready=0 and mem_rsp_ready=0 while reset is asserted.
- Reset mid-operation abandons the op. No out_valid is produced. A later bus response is drained as stale.
- FSM states are IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. On in_valid, capture the op and decode it.
  - Legal funct3 values: loads 000,001,010,100,101; stores 000,001,010.
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3, or misaligned with MISALIGN_TRAP=1: go to RESP with err=1, cause=1. No bus request.
  - Otherwise load the mem_req_* registers and go to REQ.
- REQ: mem_req_valid=1. Address, wdata and wstrb stay stable until mem_req_ready. On handshake go to WAIT and clear the counter.
- WAIT:
  - On mem_rsp_valid go to RESP. If mem_rsp_err, set err=1, cause=2, rdata=0; otherwise rdata = aligned load data.
  - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES-1 go to RESP with err=1, cause=3.
  - If a response and the timeout fall in the same cycle, the response wins.
- RESP: out_valid=1 with stable out_* until out_ready, then go to IDLE. in_ready=0 here, so no back-to-back accept.
- mem_rsp_ready=1 in every state after reset. A response arriving outside WAIT is consumed and discarded.
- Store steering (off = addr[1:0]):
  - SB: wdata = byte replicated 4x, wstrb = 4'b0001<<off.
  - SH: wdata = half replicated 2x, wstrb = 4'b0011<<off.
  - SW: wdata = in_wdata, wstrb = 4'b1111.
- Load extraction: shift rdata right by 8*off, then take the low byte or half. Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word through.
- Latency:
  - Accept at cycle T, req_ready at T+1, rsp at T+2: out_valid at T+3.
  - Error detected at decode: out_valid at T+1.

Decomposition:
- Package ysyx_25040129_lsu_pkg: state enum, cause codes (CAUSE_NONE/MISALIGN/BUSERR/TIMEOUT), funct3 constants (F3_B/H/W/BU/HU).
- Sub-module ysyx_25040129_lsu_align, purely combinational, with two functions:
  - store lane steering and strobe generation;
  - load shift and extension.
- The FSM, counter and handshake registers live in the top module.

Test Plan:
- SW addr 0x80000004 data 0xDEADBEEF, req_ready=1 -> mem_req_addr=0x80000004, wstrb=1111, wdata=0xDEADBEEF; rsp at next cycle -> out_valid at T+3, err=0.
- SB addr 0x80000003 data 0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5.
- LB addr 0x80000002, rsp rdata=0x12F00034 -> out_rdata=0xFFFFFFF0; LBU same -> 0x000000F0; LH addr+0 -> 0x00000034.
- LW addr 0x80000001, MISALIGN_TRAP=1 -> no mem_req_valid, out_valid at T+1, err=1, cause=1. With MISALIGN_TRAP=0 -> mem_req_addr=0x80000000.
- TIMEOUT_CYCLES=4, no response -> out_err=1, cause=3 after 4 WAIT cycles; response on the 4th WAIT cycle -> wins, err=0. A late response in IDLE is dropped with no out_valid.
- Bus error: mem_rsp_err=1 -> cause=2, rdata=0. Hold out_ready=0 5 cycles -> out_* stable, in_ready=0. Assert rst during REQ -> mem_req_valid=0 immediately, FSM back to IDLE.

Source files
------------

// File: rtl/ysyx_25040129_lsu_pkg.sv
// Shared definitions for the multi-cycle load/store unit.
//   lsu_state_t  : FSM states (IDLE, REQ, WAIT, RESP)
//   CAUSE_*      : out_cause encodings
//   F3_*         : RV32 load/store funct3 encodings
//   st_lanes_t   : steered store data plus byte strobes
package ysyx_25040129_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUSERR   = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } st_lanes_t;

endpackage

// File: rtl/ysyx_25040129_lsu_align.sv
// Combinational data alignment for the LSU.
//   st_funct3/st_off/st_data -> st_wdata/st_wstrb : store lane steering
//   ld_funct3/ld_off/ld_word -> ld_data           : load shift and extension
module ysyx_25040129_lsu_align
    import ysyx_25040129_lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    // Replicate the store operand across lanes so the strobe alone selects
    // the target bytes.
    function automatic st_lanes_t steer(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] d);
        st_lanes_t r;
        case (f3)
            F3_B: begin
                r.wdata = {4{d[7:0]}};
                r.wstrb = 4'b0001 << off;
            end
            F3_H: begin
                r.wdata = {2{d[15:0]}};
                r.wstrb = 4'b0011 << off;
            end
            default: begin
                r.wdata = d;
                r.wstrb = 4'b1111;
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> {off, 3'b000};
        case (f3)
            F3_B:    r = {{24{sh[7]}}, sh[7:0]};
            F3_BU:   r = {24'h000000, sh[7:0]};
            F3_H:    r = {{16{sh[15]}}, sh[15:0]};
            F3_HU:   r = {16'h0000, sh[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    st_lanes_t lanes;

    always_comb begin
        lanes    = steer(st_funct3, st_off, st_data);
        st_wdata = lanes.wdata;
        st_wstrb = lanes.wstrb;
        ld_data  = extract(ld_funct3, ld_off, ld_word);
    end

endmodule

// File: rtl/ysyx_25040129_lsu.sv
// Multi-cycle load/store unit between the execute stage and the memory bus.
//   in_*       : op handshake from EXU (store flag, funct3, byte address, store data)
//   mem_req_*  : one word-aligned bus request with byte strobes per op
//   mem_rsp_*  : bus response (read word, error); always accepted after reset
//   out_*      : result handshake (extended load data, error flag, cause)
// clk/rst: rst is asynchronous and active-low.
module ysyx_25040129_lsu
    import ysyx_25040129_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          MISALIGN_TRAP  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [31:0]       mem_rsp_rdata,
    input  logic              mem_rsp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rdata,
    output logic              out_err,
    output logic [1:0]        out_cause
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state;
    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;

    logic dec_legal;
    logic dec_misaligned;
    logic dec_trap;

    // Handshake readies are gated by reset so nothing is accepted while it is held.
    assign in_ready      = rst && (state == S_IDLE);
    assign mem_rsp_ready = rst;

    ysyx_25040129_lsu_align u_align (
        .st_funct3 (in_funct3),
        .st_off    (in_addr[1:0]),
        .st_data   (in_wdata),
        .st_wdata  (st_wdata),
        .st_wstrb  (st_wstrb),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .ld_word   (mem_rsp_rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        dec_legal      = 1'b0;
        dec_misaligned = 1'b0;
        if (in_is_store) begin
            dec_legal = (in_funct3 == F3_B) || (in_funct3 == F3_H) || (in_funct3 == F3_W);
        end else begin
            dec_legal = (in_funct3 == F3_B) || (in_funct3 == F3_H) || (in_funct3 == F3_W) ||
                        (in_funct3 == F3_BU) || (in_funct3 == F3_HU);
        end
        case (in_funct3)
            F3_H, F3_HU: dec_misaligned = in_addr[0];
            F3_W:        dec_misaligned = |in_addr[1:0];
            default:     dec_misaligned = 1'b0;
        endcase
        dec_trap = !dec_legal || (dec_misaligned && MISALIGN_TRAP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            is_store_q    <= 1'b0;
            funct3_q      <= '0;
            off_q         <= '0;
            cnt           <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            out_valid     <= 1'b0;
            out_rdata     <= '0;
            out_err       <= 1'b0;
            out_cause     <= CAUSE_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        is_store_q <= in_is_store;
                        funct3_q   <= in_funct3;
                        off_q      <= in_addr[1:0];
                        if (dec_trap) begin
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                            out_cause <= CAUSE_MISALIGN;
                            out_rdata <= '0;
                            state     <= S_RESP;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                            mem_req_wen   <= in_is_store;
                            mem_req_wdata <= in_is_store ? st_wdata : '0;
                            mem_req_wstrb <= in_is_store ? st_wstrb : '0;
                            state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response in the final counted cycle takes priority over the timeout.
                    if (mem_rsp_valid) begin
                        out_valid <= 1'b1;
                        state     <= S_RESP;
                        if (mem_rsp_err) begin
                            out_err   <= 1'b1;
                            out_cause <= CAUSE_BUSERR;
                            out_rdata <= '0;
                        end else begin
                            out_err   <= 1'b0;
                            out_cause <= CAUSE_NONE;
                            out_rdata <= is_store_q ? '0 : ld_data;
                        end
                    end else if (cnt == CNT_LAST) begin
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                        out_cause <= CAUSE_TIMEOUT;
                        out_rdata <= '0;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        out_cause <= CAUSE_NONE;
                        out_rdata <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
